// File: rtl/int_ctrl.sv
// int_ctrl: arbitrates reset, edge-triggered NMI and masked level IRQs at instruction
// boundaries and supplies the vector low byte for the active sequence.
module int_ctrl #(
    parameter int          NUM_IRQ      = 4,
    parameter int          ID_W         = 2,
    parameter int          SYNC_STAGES  = 2,
    parameter bit          VECTORED     = 1'b0,
    parameter logic [7:0]  IRQ_VEC_BASE = 8'hFE,
    parameter bit          HIJACK       = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               i_flag,
    input  logic               vec_lock,
    input  logic               int_ack,
    output logic               rst,
    output logic               nmi,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [7:0]         vec_lo,
    output logic               nmi_pending
);
    logic [SYNC_STAGES:0]   chain_q;
    logic [SYNC_STAGES+1:0] tap;
    logic                   rst_q, rst_d, nmi_q, nmi_d, irq_q, irq_d, pend_q, pend_d;
    logic                   nmi_edge, idle;
    logic [ID_W-1:0]        id_q, id_d, low_id;
    logic [NUM_IRQ-1:0]     req;
    assign tap = {chain_q, nmi_n};
    // top chain bit is the previous synchronised sample, the one below it the current one
    assign nmi_edge = tap[SYNC_STAGES+1] & ~tap[SYNC_STAGES];
    assign req = ~irq_n & irq_mask;
    assign idle = ~(rst_q | nmi_q | irq_q);
    always_comb begin
        low_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) low_id = ID_W'(i);
    end
    always_comb begin
        rst_d  = rst_q;
        nmi_d  = nmi_q;
        irq_d  = irq_q;
        id_d   = id_q;
        pend_d = pend_q | nmi_edge;
        if (!idle && int_ack) begin
            rst_d = 1'b0;
            nmi_d = 1'b0;
            irq_d = 1'b0;
            if (nmi_q) pend_d = nmi_edge;
        end else if (HIJACK && irq_q && !vec_lock && pend_q) begin
            irq_d = 1'b0;
            nmi_d = 1'b1;
        end else if (idle && sync) begin
            if (pend_q) begin
                nmi_d = 1'b1;
            end else if (|req && !i_flag) begin
                irq_d = 1'b1;
                id_d  = low_id;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '1;
            rst_q   <= 1'b1;
            nmi_q   <= 1'b0;
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            chain_q <= tap[SYNC_STAGES:0];
            rst_q   <= rst_d;
            nmi_q   <= nmi_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
        end
    end
    assign rst         = rst_q;
    assign nmi         = nmi_q;
    assign irq         = irq_q;
    assign irq_id      = id_q;
    assign nmi_pending = pend_q;
    assign vec_lo = rst_q               ? 8'hFC :
                    nmi_q               ? 8'hFA :
                    (irq_q && VECTORED) ? IRQ_VEC_BASE - 8'({id_q, 1'b0}) :
                                          8'hFE;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed plan steps followed by random traffic, all checked each cycle
// against a mode/pending reference model with a delay-line view of nmi_n.
module tb_int_ctrl;
    localparam int N = 4;
    localparam int S = 2;
    logic         clk = 1'b0, rst_n = 1'b1, sync = 1'b0, nmi_n = 1'b1;
    logic         i_flag = 1'b0, vec_lock = 1'b0, int_ack = 1'b0;
    logic [N-1:0] irq_n = '1, irq_mask = '1;
    logic         rst, nmi, irq, nmi_pending;
    logic [1:0]   irq_id;
    logic [7:0]   vec_lo;
    int           checks = 0, errors = 0;
    int           m_mode;
    int           m_id;
    bit           m_pend;
    bit           hist [S+2];

    always #5 clk = ~clk;

    int_ctrl #(.NUM_IRQ(N), .ID_W(2), .SYNC_STAGES(S), .VECTORED(1'b1),
               .IRQ_VEC_BASE(8'hFE), .HIJACK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .nmi_n(nmi_n), .irq_n(irq_n),
        .irq_mask(irq_mask), .i_flag(i_flag), .vec_lock(vec_lock), .int_ack(int_ack),
        .rst(rst), .nmi(nmi), .irq(irq), .irq_id(irq_id), .vec_lo(vec_lo),
        .nmi_pending(nmi_pending)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode: 0 idle, 1 reset, 2 nmi, 3 irq
    task automatic model_reset();
        m_mode = 1;
        m_id   = 0;
        m_pend = 1'b0;
        for (int j = 0; j < S + 2; j++) hist[j] = 1'b1;
    endtask

    task automatic model_edge();
        bit e, np;
        int low;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = nmi_n;
        e = !hist[S] && hist[S+1];
        low = -1;
        for (int j = N - 1; j >= 0; j--) if (!irq_n[j] && irq_mask[j]) low = j;
        np = m_pend | e;
        if (m_mode != 0 && int_ack) begin
            if (m_mode == 2) np = e;
            m_mode = 0;
        end else if (m_mode == 3 && !vec_lock && m_pend) begin
            m_mode = 2;
        end else if (m_mode == 0 && sync) begin
            if (m_pend) m_mode = 2;
            else if (low >= 0 && !i_flag) begin
                m_mode = 3;
                m_id = low;
            end
        end
        m_pend = np;
    endtask

    function automatic logic [7:0] exp_vec();
        return m_mode == 1 ? 8'hFC : m_mode == 2 ? 8'hFA :
               m_mode == 3 ? 8'(254 - 2 * m_id) : 8'hFE;
    endfunction

    task automatic check_all();
        chk("rst", 8'(rst), 8'(m_mode == 1));
        chk("nmi", 8'(nmi), 8'(m_mode == 2));
        chk("irq", 8'(irq), 8'(m_mode == 3));
        chk("irq_id", 8'(irq_id), 8'(m_id));
        chk("vec_lo", vec_lo, exp_vec());
        chk("nmi_pending", 8'(nmi_pending), 8'(m_pend));
        chk("onehot", 8'($countones({rst, nmi, irq}) <= 1), 8'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic areset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #2 areset();
        repeat (3) tick();
        chk("rst_hold", 8'(rst), 8'd1);
        rst_n = 1'b1;
        repeat (7) tick();
        chk("rst_before_ack", 8'(rst), 8'd1);
        chk("vec_rst", vec_lo, 8'hFC);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("rst_after_ack", 8'(rst), 8'd0);
        chk("vec_idle", vec_lo, 8'hFE);
        // NMI latency and single edge for a held-low nmi_n
        nmi_n = 1'b0;
        tick(); chk("nmi_lat1", 8'(nmi_pending), 8'd0);
        tick(); chk("nmi_lat2", 8'(nmi_pending), 8'd0);
        tick(); chk("nmi_lat3", 8'(nmi_pending), 8'd1);
        sync = 1'b1; tick(); sync = 1'b0;
        chk("nmi_taken", 8'(nmi), 8'd1);
        chk("vec_nmi", vec_lo, 8'hFA);
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("nmi_ack", 8'(nmi), 8'd0);
        chk("nmi_pend_clr", 8'(nmi_pending), 8'd0);
        sync = 1'b1; repeat (3) tick(); sync = 1'b0;
        chk("no_second_nmi", 8'(nmi), 8'd0);
        nmi_n = 1'b1; repeat (3) tick();
        // IRQ priority with mask, vectored
        irq_n = 4'b0101; irq_mask = 4'b1101;
        sync = 1'b1; tick(); sync = 1'b0;
        chk("irq_taken", 8'(irq), 8'd1);
        chk("irq_id3", 8'(irq_id), 8'd3);
        chk("vec_irq3", vec_lo, 8'hF8);
        irq_mask = '0; i_flag = 1'b1; tick();
        chk("irq_no_cancel", 8'(irq), 8'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq_mask = 4'b1101;
        sync = 1'b1; tick(); sync = 1'b0;
        chk("irq_iflag", 8'(irq), 8'd0);
        i_flag = 1'b0;
        // hijack before vec_lock
        irq_n = 4'b1110;
        sync = 1'b1; tick(); sync = 1'b0;
        chk("irq0", 8'(irq), 8'd1);
        chk("vec_irq0", vec_lo, 8'hFE);
        nmi_n = 1'b0; repeat (3) tick();
        chk("hj_pend", 8'(nmi_pending), 8'd1);
        tick();
        chk("hj_irq", 8'(irq), 8'd0);
        chk("hj_nmi", 8'(nmi), 8'd1);
        chk("hj_vec", vec_lo, 8'hFA);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        nmi_n = 1'b1; repeat (3) tick();
        // vec_lock blocks hijack
        sync = 1'b1; tick(); sync = 1'b0;
        vec_lock = 1'b1; nmi_n = 1'b0; repeat (4) tick();
        chk("lock_irq", 8'(irq), 8'd1);
        chk("lock_pend", 8'(nmi_pending), 8'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0; vec_lock = 1'b0;
        sync = 1'b1; tick(); sync = 1'b0;
        chk("lock_nmi_after", 8'(nmi), 8'd1);
        // ack of NMI colliding with a fresh edge
        nmi_n = 1'b1; repeat (3) tick();
        nmi_n = 1'b0; repeat (2) tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("collide_nmi", 8'(nmi), 8'd0);
        chk("collide_pend", 8'(nmi_pending), 8'd1);
        sync = 1'b1; tick(); sync = 1'b0;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        nmi_n = 1'b1; repeat (3) tick();
        // async reset mid-IRQ with NMI pending
        sync = 1'b1; tick(); sync = 1'b0;
        vec_lock = 1'b1; nmi_n = 1'b0; repeat (3) tick();
        areset();
        chk("ar_rst", 8'(rst), 8'd1);
        chk("ar_irq", 8'(irq), 8'd0);
        chk("ar_pend", 8'(nmi_pending), 8'd0);
        tick(); rst_n = 1'b1; vec_lock = 1'b0;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        // random traffic
        for (int k = 0; k < 4000; k++) begin
            sync     = ($urandom_range(2) == 0);
            int_ack  = ($urandom_range(5) == 0);
            vec_lock = ($urandom_range(3) == 0);
            i_flag   = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(3) == 0) irq_n = N'($urandom);
            if ($urandom_range(7) == 0) irq_mask = N'($urandom);
            if ($urandom_range(250) == 0) begin
                areset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
